approx_popcount_seq: RTL and testbench
======================================

Name: approx_popcount_seq

Overview:
- Sequential controller that time-multiplexes one 8-input compressor slice over a 128-bit input vector. It replaces the fully unrolled 16-slice tree where area matters more than throughput.
- Accepts a vector through a valid/ready handshake, then processes one 8-bit chunk per cycle for 16 cycles, accumulating the chunk counts.
- Returns the total count and its LSB (parity) through a second valid/ready handshake.
- Supports an exact mode and an approximate mode per transaction. The approximate mode ORs bits 0 and 1 of each chunk, matching the slice's approximate first stage.

Parameters:
- CHUNK_W, 8: bits compressed per cycle (fixed at 8 in this revision).
- NUM_CHUNKS, 16: chunks per vector; input width = CHUNK_W*NUM_CHUNKS = 128.
- CNT_W, 8: accumulator/count width; must hold NUM_CHUNKS*CHUNK_W = 128.

Ports:
- clk, input, 1: sole clock, rising edge.
- rst, input, 1: synchronous, active-high reset.
- in_valid, input, 1: input vector valid.
- in_ready, output, 1: block can accept a vector.
- in_data, input, 128: vector; chunk k = in_data[8k+7:8k].
- in_approx, input, 1: sampled with in_data; 1 = approximate mode, 0 = exact mode.
- clear, input, 1: synchronous soft abort.
- busy, output, 1: high in RUN.
- out_valid, output, 1: result valid.
- out_ready, input, 1: consumer accepts the result.
- out_count, output, 8: accumulated count.
- out_parity, output, 1: out_count[0].

Behaviour:
- States and registers:
  - FSM states: IDLE, RUN, DONE.
  - Registers: data_q[127:0], approx_q, idx[3:0], acc[7:0].
- Reset (rst=1 at a rising edge):
  - state=IDLE, idx=0, acc=0.
  - out_valid=0, out_count=0, out_parity=0, busy=0, in_ready=1.
  - Reset overrides everything, including mid-RUN and DONE with the result not yet taken; that result is discarded.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, clear=0, rst=0: latch data_q, approx_q; set idx=0, acc=0; go to RUN.
- RUN:
  - in_ready=0, busy=1.
  - Each edge: acc <= acc + chunk_cnt(data_q chunk idx); idx <= idx+1.
  - On the edge where idx=15 is processed: go to DONE; idx wraps to 0.
- chunk_cnt:
  - Exact mode: popcount of the 8 bits (0..8).
  - Approximate mode: (b0|b1) + popcount(b7..b2) (0..7).
  - Computed combinationally from the currently indexed chunk; no extra pipeline stage.
- DONE:
  - out_valid=1; out_count=acc; out_parity=acc[0]; in_ready=0.
  - Outputs are held stable while out_ready=0, indefinitely.
  - On an edge with out_ready=1: go to IDLE, out_valid=0.
  - out_count and out_parity retain their last value after the handshake and are valid only while out_valid=1.
- Latency:
  - Input accepted at edge E0; chunks processed at E1..E16; out_valid=1 after E16.
  - A vector offered in the same cycle a result is taken waits one cycle (in_ready is asserted only in IDLE).
  - Maximum throughput: one vector per 18 cycles.
- clear:
  - In RUN or DONE: next state IDLE, acc=0, out_valid=0; a pending result is discarded.
  - In IDLE with in_valid=1: clear wins and the vector is not accepted.
- Arithmetic:
  - Unsigned.
  - Maximum sum is 128 (exact) or 112 (approximate), so acc cannot overflow 8 bits; no saturation logic.
- in_data and in_approx are ignored outside the IDLE accept edge; changes during RUN have no effect.

Test Plan:
- Reset then all-ones in_data, in_approx=0 -> out_valid rises exactly 17 edges after rst release plus accept, with out_count=128, out_parity=0. Repeat with in_approx=1 -> out_count=112.
- in_data = {16{8'hAA}} -> exact 64, approximate 64. in_data = {16{8'h03}} -> exact 32, approximate 16 with parity 0. in_data = 128'h1 in exact mode -> count 1, parity 1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_count stable and in_ready=0 throughout. Then pulse out_ready=1 -> next cycle out_valid=0, in_ready=1.
- Back-to-back: keep in_valid=1 with two vectors (all-zero, then all-ones exact) and out_ready=1 -> results 0 then 128. Second accept occurs one cycle after the first result handshake.
- clear at cycle 5 of RUN -> IDLE next cycle, out_valid never asserts. A new vector of 8'hFF in chunk 0 only -> count 8. clear and in_valid together in IDLE -> no accept.
- rst asserted mid-RUN and again in DONE -> all outputs return to reset values on the next edge, in_ready=1, and a subsequent transaction is correct.

Source files
------------

// File: rtl/approx_popcount_seq.sv
// Time-multiplexed popcount: one 8-bit compressor slice walks a 128-bit vector,
// one chunk per cycle, with an optional approximate first stage (b0|b1).
module approx_popcount_seq #(
  parameter int CHUNK_W    = 8,
  parameter int NUM_CHUNKS = 16,
  parameter int CNT_W      = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [CHUNK_W*NUM_CHUNKS-1:0] in_data,
  input  logic                          in_approx,
  input  logic                          clear,
  output logic                          busy,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [CNT_W-1:0]              out_count,
  output logic                          out_parity
);

  localparam int DATA_W = CHUNK_W * NUM_CHUNKS;
  localparam int IDX_W  = $clog2(NUM_CHUNKS);
  localparam int CCW    = $clog2(CHUNK_W + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]        state_q,  state_d;
  logic [DATA_W-1:0] data_q,   data_d;
  logic              approx_q, approx_d;
  logic [IDX_W-1:0]  idx_q,    idx_d;
  logic [CNT_W-1:0]  acc_q,    acc_d;

  logic [CHUNK_W-1:0] chunk;
  logic [CCW-1:0]     chunk_n;

  // Approximate mode merges the two LSBs with an OR before the adder tree.
  function automatic logic [CCW-1:0] chunk_cnt(input logic [CHUNK_W-1:0] c,
                                               input logic approx);
    logic [CCW-1:0] n;
    n = '0;
    for (int i = 2; i < CHUNK_W; i++) n = n + CCW'(c[i]);
    if (approx) n = n + CCW'(c[0] | c[1]);
    else        n = n + CCW'(c[0]) + CCW'(c[1]);
    return n;
  endfunction

  assign chunk   = data_q[idx_q*CHUNK_W +: CHUNK_W];
  assign chunk_n = chunk_cnt(chunk, approx_q);

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    approx_d = approx_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    if (clear) begin
      // Abort discards any partial or pending result; IDLE keeps its acc.
      state_d = ST_IDLE;
      idx_d   = '0;
      if (state_q != ST_IDLE) acc_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            data_d   = in_data;
            approx_d = in_approx;
            idx_d    = '0;
            acc_d    = '0;
            state_d  = ST_RUN;
          end
        end
        ST_RUN: begin
          acc_d = acc_q + CNT_W'(chunk_n);
          idx_d = idx_q + 1'b1;
          if (idx_q == IDX_W'(NUM_CHUNKS - 1)) state_d = ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    data_q   <= data_d;
    approx_q <= approx_d;
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
    end
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign busy       = (state_q == ST_RUN);
  assign out_valid  = (state_q == ST_DONE);
  assign out_count  = acc_q;
  assign out_parity = acc_q[0];

endmodule

// File: tb/tb_approx_popcount_seq.sv
// Bench for approx_popcount_seq: transaction-level reference model plus
// directed scenarios with literal expectations and a randomized run.
module tb_approx_popcount_seq;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_approx, clear, out_ready;
  logic [127:0] in_data;
  logic         in_ready, busy, out_valid, out_parity;
  logic [7:0]   out_count;

  always #5 clk = ~clk;

  approx_popcount_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_approx(in_approx), .clear(clear), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count),
    .out_parity(out_parity)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Count = popcount, minus one per chunk whose b0 and b1 are both set in approx mode.
  function automatic int ref_count(input logic [127:0] d, input bit a);
    logic [127:0] lsb_mask;
    int c;
    lsb_mask = {16{8'h01}};
    c = $countones(d);
    if (a) c = c - $countones(d & (d >> 1) & lsb_mask);
    return c;
  endfunction

  // Transaction model: a vector is busy for 16 cycles, then a result waits for out_ready.
  bit m_init = 0, m_run = 0, m_have = 0;
  int m_cyc = 0, m_exp = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_init = 1; m_run = 0; m_have = 0; m_cyc = 0;
    end else if (clear) begin
      m_run = 0; m_have = 0;
    end else if (m_run) begin
      m_cyc++;
      if (m_cyc == 16) begin m_run = 0; m_have = 1; end
    end else if (m_have) begin
      if (out_ready) m_have = 0;
    end else if (in_valid) begin
      m_run = 1; m_cyc = 0; m_exp = ref_count(in_data, in_approx);
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      check("model_in_ready", in_ready, !m_run && !m_have);
      check("model_busy", busy, m_run);
      check("model_out_valid", out_valid, m_have);
      if (m_have) begin
        check("model_out_count", out_count, m_exp);
        check("model_out_parity", out_parity, m_exp & 1);
      end
    end
  end

  task automatic wait_valid(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      @(posedge clk); #1; n++;
    end
    if (out_valid !== 1'b1) check("wait_valid_timeout", out_valid, 1);
  endtask

  task automatic send(input logic [127:0] d, input bit a, input int exp_cnt, input string nm);
    int n;
    in_data = d; in_approx = a; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(n);
    check({nm, "_latency"}, n, 16);
    check({nm, "_count"}, out_count, exp_cnt);
    check({nm, "_parity"}, out_parity, exp_cnt & 1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({nm, "_taken_valid"}, out_valid, 0);
    check({nm, "_taken_ready"}, in_ready, 1);
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, "_in_ready"}, in_ready, 1);
    check({nm, "_busy"}, busy, 0);
    check({nm, "_out_valid"}, out_valid, 0);
    check({nm, "_out_count"}, out_count, 0);
    check({nm, "_out_parity"}, out_parity, 0);
  endtask

  logic [127:0] ones;

  initial begin
    int n;
    int seen;
    ones = '1;
    rst = 1'b1; in_valid = 1'b0; in_approx = 1'b0; clear = 1'b0;
    out_ready = 1'b0; in_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_outputs("reset");

    check("ref_ones_exact", ref_count(ones, 0), 128);
    check("ref_ones_approx", ref_count(ones, 1), 112);
    check("ref_aa_approx", ref_count({16{8'hAA}}, 1), 64);
    check("ref_03_approx", ref_count({16{8'h03}}, 1), 16);
    check("ref_one_bit", ref_count(128'h1, 0), 1);

    send(ones, 0, 128, "ones_exact");
    send(ones, 1, 112, "ones_approx");
    send({16{8'hAA}}, 0, 64, "aa_exact");
    send({16{8'hAA}}, 1, 64, "aa_approx");
    send({16{8'h03}}, 0, 32, "x03_exact");
    send({16{8'h03}}, 1, 16, "x03_approx");
    send(128'h1, 0, 1, "single_bit");
    send(128'h8000_0000_0000_0000_0000_0000_0000_0001, 1, 2, "two_ends");

    // Backpressure in DONE
    in_data = ones; in_approx = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    wait_valid(n);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_count", out_count, 128);
      check("bp_in_ready", in_ready, 0);
      check("bp_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    check("bp_release_valid", out_valid, 0);
    check("bp_release_ready", in_ready, 1);

    // Back-to-back with in_valid held high
    in_data = '0; in_approx = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1 in_data = ones;
    wait_valid(n);
    check("b2b_first_count", out_count, 0);
    @(posedge clk); #1;
    check("b2b_gap_ready", in_ready, 1);
    check("b2b_gap_busy", busy, 0);
    @(posedge clk); #1;
    check("b2b_second_accept", busy, 1);
    in_valid = 1'b0;
    wait_valid(n);
    check("b2b_second_count", out_count, 128);
    @(posedge clk); #1 out_ready = 1'b0;

    // Clear mid-RUN
    in_data = ones; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
    check("clr_ready", in_ready, 1);
    check("clr_busy", busy, 0);
    seen = 0;
    repeat (20) begin @(posedge clk); #1; if (out_valid) seen = 1; end
    check("clr_no_valid", seen, 0);
    send({120'b0, 8'hFF}, 0, 8, "chunk0_ff");
    clear = 1'b1; in_valid = 1'b1; in_data = ones;
    @(posedge clk); #1 clear = 1'b0; in_valid = 1'b0;
    check("clr_idle_busy", busy, 0);
    check("clr_idle_ready", in_ready, 1);

    // Reset mid-RUN and in DONE
    in_data = ones; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check_reset_outputs("rst_run");
    in_data = ones; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    wait_valid(n);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check_reset_outputs("rst_done");
    send({16{8'hAA}}, 1, 64, "after_rst");

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      in_approx = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 9) < 6);
      clear     = ($urandom_range(0, 79) == 0);
      rst       = ($urandom_range(0, 299) == 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; clear = 1'b0; rst = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end

endmodule
